// File: rtl/psum_pkg.sv
// Shared types for the psum GLB write-back path: default widths, the
// buffered entry layout and the controller state encoding.
package psum_pkg;

    localparam int PSUM_DATA_W = 16;
    localparam int PSUM_ADDR_W = 16;

    // One buffered write: target address, (possibly clamped) data, row-end flag.
    typedef struct packed {
        logic [PSUM_ADDR_W-1:0] addr;
        logic [PSUM_DATA_W-1:0] data;
        logic                   last;
    } psum_entry_t;

    localparam int PSUM_ENTRY_W = $bits(psum_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } psum_state_t;

endpackage

// File: rtl/psum_wb_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rdata_o whenever
// count_o is non-zero. Pushes into a full FIFO and pops from an empty one are
// ignored, so the owner may drive push_i/pop_i from raw handshakes.
module psum_wb_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Qualify handshakes against fill level and compute next pointers/count.
    always_comb begin
        do_push  = push_i && (count_q != CW'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and fill-level registers; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/psum_glb_writer.sv
// Buffers finished partial sums from the psum controller and writes them to
// the GLB. Applies optional ReLU on accept, counts output rows to flag each
// completed feature map, and supports a flush/drain handshake.
//
// Handshakes: upstream word transfers when psum_valid && in_ready at a rising
// edge; a GLB write transfers when glb_wr_en && glb_grant at a rising edge.
// While a request is pending and not granted, glb_wr_en/glb_addr/glb_wdata
// hold their values.
module psum_glb_writer
    import psum_pkg::*;
#(
    parameter int DATA_W       = PSUM_DATA_W,
    parameter int ADDR_W       = PSUM_ADDR_W,
    parameter int DEPTH        = 8,
    parameter int ROWS_PER_MAP = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                psum_valid,
    input  logic [DATA_W-1:0]                   psum_data,
    input  logic [ADDR_W-1:0]                   psum_addr,
    input  logic                                psum_last,
    output logic                                in_ready,
    input  logic                                relu_en,
    input  logic                                flush,
    output logic                                glb_wr_en,
    output logic [ADDR_W-1:0]                   glb_addr,
    output logic [DATA_W-1:0]                   glb_wdata,
    input  logic                                glb_grant,
    output logic                                map_done,
    output logic                                flush_done,
    output logic [$clog2(DEPTH):0]              occupancy,
    output psum_state_t                         dbg_state,
    output logic [$clog2(ROWS_PER_MAP+1)-1:0]   dbg_row_cnt
);

    // DATA_W/ADDR_W are expected to match the package entry layout widths.
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = $clog2(ROWS_PER_MAP + 1);

    psum_state_t   state_q, state_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic          map_done_q, map_done_d;
    logic          flush_done_q, flush_done_d;

    logic [CW-1:0] occ;
    psum_entry_t   entry_in;
    psum_entry_t   head;
    logic          push, pop;

    // Accept side: ReLU clamp and packing of the new entry.
    always_comb begin
        entry_in      = '0;
        entry_in.addr = psum_addr;
        entry_in.data = (relu_en && psum_data[DATA_W-1]) ? '0 : psum_data;
        entry_in.last = psum_last;
    end

    assign in_ready = (occ != CW'(DEPTH)) && (state_q != ST_FLUSH) && (state_q != ST_DONE);
    assign push     = psum_valid && in_ready;

    // Write side: requests come straight from registered fill level and head
    // entry; reset suppresses any write in the reset cycle.
    assign glb_wr_en = (occ != '0) && !rst;
    assign glb_addr  = glb_wr_en ? head.addr : '0;
    assign glb_wdata = glb_wr_en ? head.data : '0;
    assign pop       = glb_wr_en && glb_grant;

    psum_wb_fifo #(
        .W     (PSUM_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i (entry_in),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (occ)
    );

    // Row counter: advances on each written row end, wraps per map; cleared
    // when a flush completes so the next map starts from row 0.
    always_comb begin
        row_cnt_d  = row_cnt_q;
        map_done_d = 1'b0;
        if (state_q == ST_DONE) begin
            row_cnt_d = '0;
        end else if (pop && head.last) begin
            if (row_cnt_q == RW'(ROWS_PER_MAP - 1)) begin
                row_cnt_d  = '0;
                map_done_d = 1'b1;
            end else begin
                row_cnt_d = row_cnt_q + RW'(1);
            end
        end
    end

    // Controller next state: tracks empty/non-empty and sequences the flush.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (push) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if ((occ == CW'(1)) && pop && !push) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (occ == '0) begin
                    state_d      = ST_DONE;
                    flush_done_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (!flush) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller, row counter and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_cnt_q    <= '0;
            map_done_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            map_done_q   <= map_done_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign map_done    = map_done_q;
    assign flush_done  = flush_done_q;
    assign occupancy   = occ;
    assign dbg_state   = state_q;
    assign dbg_row_cnt = row_cnt_q;

endmodule

// File: tb/tb_psum_glb_writer.sv
// Bench for psum_glb_writer: directed scenarios plus a randomized phase,
// with a queue-based reference model checked by an independent monitor.
module tb_psum_glb_writer;
    import psum_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 8;
    localparam int ROWS   = 5;
    localparam int EW     = ADDR_W + DATA_W + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              psum_valid;
    logic [DATA_W-1:0] psum_data;
    logic [ADDR_W-1:0] psum_addr;
    logic              psum_last;
    logic              in_ready;
    logic              relu_en;
    logic              flush;
    logic              glb_wr_en;
    logic [ADDR_W-1:0] glb_addr;
    logic [DATA_W-1:0] glb_wdata;
    logic              glb_grant;
    logic              map_done;
    logic              flush_done;
    logic [3:0]        occupancy;
    psum_state_t       dbg_state;
    logic [2:0]        dbg_row_cnt;

    // Scoreboard state
    logic [EW-1:0] exp_q[$];
    int checks      = 0;
    int failures    = 0;
    int writes      = 0;
    int map_pulses  = 0;
    int flush_pulses = 0;
    int model_rows  = 0;
    bit map_pend    = 1'b0;
    bit chk_ready   = 1'b1;

    psum_glb_writer #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .DEPTH        (DEPTH),
        .ROWS_PER_MAP (ROWS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .psum_valid  (psum_valid),
        .psum_data   (psum_data),
        .psum_addr   (psum_addr),
        .psum_last   (psum_last),
        .in_ready    (in_ready),
        .relu_en     (relu_en),
        .flush       (flush),
        .glb_wr_en   (glb_wr_en),
        .glb_addr    (glb_addr),
        .glb_wdata   (glb_wdata),
        .glb_grant   (glb_grant),
        .map_done    (map_done),
        .flush_done  (flush_done),
        .occupancy   (occupancy),
        .dbg_state   (dbg_state),
        .dbg_row_cnt (dbg_row_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of the accept-side ReLU: negative values become zero.
    function automatic logic [DATA_W-1:0] model_relu(input logic [DATA_W-1:0] d, input logic en);
        if (en && ($signed(d) < 0)) return '0;
        return d;
    endfunction

    // Monitor: checks against the model at the falling edge, then applies this
    // cycle's write and accept handshakes to the model.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) begin
            chk("wr_en_in_reset", 64'(glb_wr_en), 64'd0);
            exp_q.delete();
            model_rows = 0;
            map_pend   = 1'b0;
        end else begin
            chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
            chk("wr_en_level", 64'(glb_wr_en), 64'(exp_q.size() != 0));
            if (chk_ready) chk("in_ready_level", 64'(in_ready), 64'(exp_q.size() != DEPTH));
            chk("map_done_timing", 64'(map_done), 64'(map_pend));
            if (map_done) map_pulses++;
            if (flush_done) flush_pulses++;
            map_pend = 1'b0;
            if (glb_wr_en && exp_q.size() != 0) begin
                e = exp_q[0];
                chk("glb_addr", 64'(glb_addr), 64'(e[EW-1 -: ADDR_W]));
                chk("glb_wdata", 64'(glb_wdata), 64'(e[DATA_W:1]));
            end
            if (glb_wr_en && glb_grant) begin
                writes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e[0]) begin
                        model_rows++;
                        if (model_rows == ROWS) begin
                            model_rows = 0;
                            map_pend   = 1'b1;
                        end
                    end
                end
            end
            if (psum_valid && in_ready) begin
                exp_q.push_back({psum_addr, model_relu(psum_data, relu_en), psum_last});
            end
        end
    end

    // Driver tasks
    task automatic reset_dut();
        rst = 1'b1; psum_valid = 0; psum_data = 0; psum_addr = 0; psum_last = 0;
        relu_en = 0; flush = 0; glb_grant = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic l);
        bit acc = 1'b0;
        psum_valid = 1'b1; psum_addr = a; psum_data = d; psum_last = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        psum_valid = 1'b0;
        if (!acc) chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_empty();
        bit done = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w0, m0, f0;
        bit got;

        // Reset state
        reset_dut();
        @(negedge clk);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_wr_en", 64'(glb_wr_en), 64'd0);
        chk("rst_addr", 64'(glb_addr), 64'd0);
        chk("rst_wdata", 64'(glb_wdata), 64'd0);
        chk("rst_map_done", 64'(map_done), 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(posedge clk); #1;

        // Single write with one-cycle latency
        w0 = writes;
        glb_grant = 1'b1;
        push_word(16'h0010, 16'h0123, 1'b0);
        @(negedge clk);
        chk("single_wr_en", 64'(glb_wr_en), 64'd1);
        chk("single_addr", 64'(glb_addr), 64'h0010);
        chk("single_data", 64'(glb_wdata), 64'h0123);
        @(negedge clk);
        chk("single_wr_en_after", 64'(glb_wr_en), 64'd0);
        chk("single_occ_after", 64'(occupancy), 64'd0);
        chk("single_write_count", 64'(writes - w0), 64'd1);
        @(posedge clk); #1;

        // Backpressure: fill to DEPTH, hold, then drain in order
        w0 = writes;
        glb_grant = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_word(ADDR_W'(16'h0200 + i), DATA_W'($urandom), 1'b0);
        psum_valid = 1'b1; psum_addr = 16'h0208; psum_data = 16'h0aaa; psum_last = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_full", 64'(in_ready), 64'd0);
        chk("bp_occ_full", 64'(occupancy), 64'd8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_addr", 64'(glb_addr), 64'h0200);
            chk("bp_hold_wr_en", 64'(glb_wr_en), 64'd1);
        end
        @(posedge clk); #1;
        glb_grant = 1'b1;
        push_word(16'h0208, 16'h0aaa, 1'b0);
        wait_empty();
        chk("bp_write_count", 64'(writes - w0), 64'd9);

        // ReLU clamp on accept
        glb_grant = 1'b1;
        relu_en = 1'b1;
        push_word(16'h0300, 16'hfff0, 1'b0);
        push_word(16'h0301, 16'h0005, 1'b0);
        relu_en = 1'b0;
        push_word(16'h0302, 16'hfff0, 1'b0);
        wait_empty();

        // Map counter: 5 rows of 3 words
        reset_dut();
        m0 = map_pulses;
        glb_grant = 1'b1;
        for (int i = 0; i < 3 * ROWS; i++) push_word(ADDR_W'(16'h0400 + i), DATA_W'(i + 1), (i % 3) == 2);
        wait_empty();
        chk("map_pulse_count", 64'(map_pulses - m0), 64'd1);
        chk("map_row_cnt", 64'(dbg_row_cnt), 64'd0);

        // Flush with buffered words
        reset_dut();
        w0 = writes; f0 = flush_pulses;
        glb_grant = 1'b0;
        for (int i = 0; i < 4; i++) push_word(ADDR_W'(16'h0500 + i), DATA_W'($urandom), i == 3);
        chk_ready = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        glb_grant = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (flush_done) begin
                got = 1'b1;
                break;
            end
            chk("flush_in_ready_drain", 64'(in_ready), 64'd0);
        end
        chk("flush_done_seen", 64'(got), 64'd1);
        chk("flush_state_done", 64'(dbg_state), 64'(ST_DONE));
        @(posedge clk); #1;
        model_rows = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("done_in_ready", 64'(in_ready), 64'd0);
            chk("done_hold_state", 64'(dbg_state), 64'(ST_DONE));
            chk("done_row_cnt", 64'(dbg_row_cnt), 64'd0);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_idle", 64'(dbg_state), 64'(ST_IDLE));
        chk("flush_in_ready_back", 64'(in_ready), 64'd1);
        chk("flush_write_count", 64'(writes - w0), 64'd4);
        chk("flush_pulse_count", 64'(flush_pulses - f0), 64'd1);
        chk_ready = 1'b1;
        @(posedge clk); #1;

        // Reset mid-fill
        glb_grant = 1'b0;
        for (int i = 0; i < 5; i++) push_word(ADDR_W'(16'h0600 + i), DATA_W'($urandom), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_wr_en", 64'(glb_wr_en), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        w0 = writes;
        @(negedge clk);
        chk("midrst_occ", 64'(occupancy), 64'd0);
        chk("midrst_wr_en_after", 64'(glb_wr_en), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        glb_grant = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_writes", 64'(writes - w0), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            psum_valid = ($urandom_range(0, 9) < 6);
            psum_data  = DATA_W'($urandom);
            psum_addr  = ADDR_W'($urandom);
            psum_last  = ($urandom_range(0, 2) == 0);
            relu_en    = $urandom_range(0, 1);
            glb_grant  = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        psum_valid = 1'b0;
        glb_grant  = 1'b1;
        wait_empty();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
